// File: rtl/ref_mb_loader.sv
// Reference macroblock store: loads a raster stream of MB_DIM x MB_DIM pixels, then serves
// edge-clamped 6-tap pixel windows (horizontal or vertical) through a one-entry output register.
module ref_mb_loader #(
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned MB_DIM = 16,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PIX_W-1:0]     in_pix,
  input  logic                 in_last,
  output logic                 load_done,
  output logic                 load_err,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic                 req_dir,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [6*PIX_W-1:0]   rsp_window
);

  localparam int unsigned Depth  = MB_DIM * MB_DIM;
  localparam int unsigned DimW   = $clog2(MB_DIM);
  localparam int unsigned CoordW = ADDR_W + 2;
  localparam logic signed [CoordW-1:0] MaxCoord = CoordW'(MB_DIM - 1);
  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(Depth - 1);

  typedef enum logic {StLoad, StServe} state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     wcnt_q, wcnt_d;
  logic                  err_q, err_d;
  logic                  rdy_q;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [6*PIX_W-1:0]    rsp_window_q, rsp_window_d;
  logic [PIX_W-1:0]      mem_q [Depth];

  logic                  beat, req_fire, last_beat;
  logic [6*PIX_W-1:0]    win;
  logic signed [CoordW-1:0] base, pos;
  logic [DimW-1:0]       cpos;
  logic [ADDR_W-1:0]     idx;

  assign in_ready   = (state_q == StLoad) & rdy_q;
  assign req_ready  = (state_q == StServe) & (~rsp_valid_q | rsp_ready);
  assign load_done  = (state_q == StServe);
  assign load_err   = err_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_window = rsp_window_q;

  assign beat      = in_valid & in_ready;
  assign req_fire  = req_valid & req_ready;
  assign last_beat = (wcnt_q == LastIdx);

  // Window gather: the stepped coordinate (row or column) is clamped, the other one is kept.
  always_comb begin
    win  = '0;
    base = '0;
    pos  = '0;
    cpos = '0;
    idx  = '0;
    for (int k = 0; k < 6; k++) begin
      base = req_dir ? CoordW'(req_addr[ADDR_W-1:DimW]) : CoordW'(req_addr[DimW-1:0]);
      pos  = base + CoordW'(k) - CoordW'(3);
      if (pos[CoordW-1]) begin
        cpos = '0;
      end else if (pos > MaxCoord) begin
        cpos = DimW'(MB_DIM - 1);
      end else begin
        cpos = pos[DimW-1:0];
      end
      idx = req_dir ? {cpos, req_addr[DimW-1:0]} : {req_addr[ADDR_W-1:DimW], cpos};
      win[k*PIX_W +: PIX_W] = mem_q[idx];
    end
  end

  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    err_d        = err_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_window_d = rsp_window_q;
    if (flush) begin
      state_d     = StLoad;
      wcnt_d      = '0;
      err_d       = 1'b0;
      rsp_valid_d = 1'b0;
    end else begin
      if (beat) begin
        // Completion is purely count-based; in_last only feeds the error flag.
        wcnt_d = last_beat ? '0 : wcnt_q + 1'b1;
        if (last_beat) state_d = StServe;
        if (in_last != last_beat) err_d = 1'b1;
      end
      if (req_fire) begin
        rsp_valid_d  = 1'b1;
        rsp_window_d = win;
      end else if (rsp_ready) begin
        rsp_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StLoad;
      wcnt_q       <= '0;
      err_q        <= 1'b0;
      rdy_q        <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_window_q <= '0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      err_q        <= err_d;
      rdy_q        <= 1'b1;
      rsp_valid_q  <= rsp_valid_d;
      rsp_window_q <= rsp_window_d;
    end
  end

  // Pixel array carries no reset.
  always_ff @(posedge clk) begin
    if (beat && !flush && !rst) begin
      mem_q[wcnt_q] <= in_pix;
    end
  end

endmodule
